// File: rtl/memory_map_pkg.sv
// Purpose: address map, timer register selector and RAM limit helper shared by RTL and CPU programs.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package memory_map_pkg;

    localparam logic [31:0] RAM_BASE           = 32'h0000_0000;
    localparam logic [31:0] GPIO_OUT_ADDR      = 32'h1000_0000;
    localparam logic [31:0] GPIO_IN_ADDR       = 32'h1000_0004;
    localparam logic [31:0] TIMER_COUNT_ADDR   = 32'h1000_0008;
    localparam logic [31:0] TIMER_COMPARE_ADDR = 32'h1000_000C;
    localparam logic [31:0] TIMER_CONTROL_ADDR = 32'h1000_0010;
    localparam logic [31:0] TIMER_STATUS_ADDR  = 32'h1000_0014;

    localparam int unsigned RAM_WORDS_MAX = 1024;

    // Register select handed from the top-level decoder to the timer.
    typedef enum logic [2:0] {
        TREG_NONE,
        TREG_COUNT,
        TREG_COMPARE,
        TREG_CONTROL,
        TREG_STATUS
    } timer_reg_e;

    // Highest byte address that still belongs to the data RAM.
    function automatic logic [31:0] ram_limit(input int unsigned words);
        return RAM_BASE + 32'(words * 4) - 32'd1;
    endfunction

endpackage

// File: rtl/timer.sv
// Purpose: free-running compare timer (COUNT/COMPARE/CONTROL/STATUS) behind a select/write/read register port.
// Latency: register writes take effect at the edge; rd_data is combinational; irq is the match flop itself.
// Backpressure: none, every access completes in one cycle.
// Ports: clock, reset (sync, active-high), reg_sel, wr_en, wr_data, rd_data, irq.
module timer
    import memory_map_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  timer_reg_e  reg_sel,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        enable_q,  enable_d;
    logic        match_q,   match_d;
    logic        hit;

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        enable_d  = enable_q;
        match_d   = match_q;

        // Compare uses the pre-edge count, so the flag rises at the edge leaving COMPARE.
        hit = enable_q && (count_q == compare_q);

        if (enable_q) begin
            count_d = count_q + 32'd1;
        end

        if (wr_en) begin
            unique case (reg_sel)
                TREG_COUNT:   count_d   = wr_data;   // overrides this cycle's increment
                TREG_COMPARE: compare_d = wr_data;
                TREG_CONTROL: enable_d  = wr_data[0];
                TREG_STATUS:  if (wr_data[0]) match_d = 1'b0;
                default:      ;
            endcase
        end

        // A hit in the same cycle as a clear must keep the flag set.
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            enable_q  <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            enable_q  <= enable_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        unique case (reg_sel)
            TREG_COUNT:   rd_data = count_q;
            TREG_COMPARE: rd_data = compare_q;
            TREG_CONTROL: rd_data = {31'd0, enable_q};
            TREG_STATUS:  rd_data = {31'd0, match_q};
            default:      rd_data = 32'd0;
        endcase
    end

    assign irq = match_q;

endmodule

// File: rtl/memory_responder.sv
// Purpose: CPU-side memory responder: word RAM, GPIO out/in (2-flop sync) and a compare timer.
// Latency: reads are combinational from pre-edge state; writes commit at the rising edge.
// Backpressure: none, the CPU may read or write every cycle.
// Ports: clock, reset (sync, active-high), address, write_enable, write_data, read_data, gpio_in, gpio_out, timer_irq.
module memory_responder
    import memory_map_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [31:0]   word_addr;
    logic          ram_hit;
    logic          ram_we;
    logic [AW-1:0] ram_idx;
    timer_reg_e    tsel;
    logic [31:0]   timer_rd;

    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] sync1_q,    sync1_d;
    logic [7:0] sync2_q,    sync2_d;

    // Byte-lane bits never take part in decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^address[1:0];

    assign word_addr = {address[31:2], 2'b00};
    // Anything above the RAM limit is unmapped, so aliases of the RAM read 0.
    assign ram_hit   = (address <= ram_limit(RAM_WORDS));
    assign ram_idx   = address[AW+1:2];
    // Reset blocks RAM writes but never clears the array.
    assign ram_we    = write_enable && ram_hit && !reset;

    always_comb begin
        tsel = TREG_NONE;
        case (word_addr)
            TIMER_COUNT_ADDR:   tsel = TREG_COUNT;
            TIMER_COMPARE_ADDR: tsel = TREG_COMPARE;
            TIMER_CONTROL_ADDR: tsel = TREG_CONTROL;
            TIMER_STATUS_ADDR:  tsel = TREG_STATUS;
            default:            tsel = TREG_NONE;
        endcase
    end

    timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .reg_sel (tsel),
        .wr_en   (write_enable),
        .wr_data (write_data),
        .rd_data (timer_rd),
        .irq     (timer_irq)
    );

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= write_data;
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (write_enable && (word_addr == GPIO_OUT_ADDR)) begin
            gpio_out_d = write_data[7:0];
        end
        sync1_d = gpio_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gpio_out_q <= 8'd0;
            sync1_q    <= 8'd0;
            sync2_q    <= 8'd0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign gpio_out = gpio_out_q;

    always_comb begin
        read_data = 32'd0;
        if (ram_hit) begin
            read_data = ram_mem[ram_idx];
        end else begin
            case (word_addr)
                GPIO_OUT_ADDR: read_data = {24'd0, gpio_out_q};
                GPIO_IN_ADDR:  read_data = {24'd0, sync2_q};
                default:       read_data = timer_rd;  // zero for non-timer addresses
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

    localparam logic [31:0] A_GOUT = 32'h1000_0000;
    localparam logic [31:0] A_GIN  = 32'h1000_0004;
    localparam logic [31:0] A_CNT  = 32'h1000_0008;
    localparam logic [31:0] A_CMP  = 32'h1000_000C;
    localparam logic [31:0] A_CTL  = 32'h1000_0010;
    localparam logic [31:0] A_STS  = 32'h1000_0014;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];

    memory_responder #(.RAM_WORDS(256)) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .timer_irq    (timer_irq)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic cmp(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, e);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        address = addr;
        exp_q.push_back(exp);
        #1;
        cmp(tag, read_data);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        exp_q.push_back({31'd0, exp});
        #1;
        cmp(tag, {31'd0, timer_irq});
    endtask

    task automatic chk_gpio(input logic [7:0] exp, input string tag);
        exp_q.push_back({24'd0, exp});
        #1;
        cmp(tag, {24'd0, gpio_out});
    endtask

    // One write: drive at the falling edge, commit at the rising edge, release.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        address      = addr;
        write_data   = data;
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        address      = 32'd0;
        write_enable = 1'b0;
        write_data   = 32'd0;
        gpio_in      = 8'd0;
        idle(2);

        // Reset state
        chk_gpio(8'h00, "rst_gpio_out");
        chk_irq(1'b0, "rst_irq");
        rd(A_CNT, 32'd0,         "rst_count");
        rd(A_CMP, 32'hFFFF_FFFF, "rst_compare");
        rd(A_CTL, 32'd0,         "rst_control");
        rd(A_STS, 32'd0,         "rst_status");
        reset = 1'b0;
        idle(1);

        // RAM: same-cycle read sees old data, next cycle sees new
        wr(32'h0000_0010, 32'h1111_1111);
        address      = 32'h0000_0010;
        write_data   = 32'hDEAD_BEEF;
        write_enable = 1'b1;
        rd(32'h0000_0010, 32'h1111_1111, "ram_same_cycle_old");
        @(negedge clock);
        write_enable = 1'b0;
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_next_cycle_new");
        rd(32'h0000_0012, 32'hDEAD_BEEF, "ram_lsb_ignored");
        wr(32'h0000_0000, 32'h0000_0000);
        wr(32'h0000_0400, 32'h5555_5555);
        rd(32'h0000_0000, 32'h0000_0000, "ram_alias_write_ignored");
        rd(32'h0000_0400, 32'h0000_0000, "ram_alias_read_zero");
        wr(32'h0000_03FC, 32'hCAFE_F00D);
        rd(32'h0000_03FC, 32'hCAFE_F00D, "ram_last_word");
        rd(32'h1000_0018, 32'h0000_0000, "unmapped_zero");

        // GPIO
        wr(A_GOUT, 32'h0000_01A5);
        chk_gpio(8'hA5, "gpio_out_pin");
        rd(A_GOUT, 32'h0000_00A5, "gpio_out_read");
        gpio_in = 8'h3C;
        rd(A_GIN, 32'h0000_0000, "gpio_in_0cyc");
        idle(1);
        rd(A_GIN, 32'h0000_0000, "gpio_in_1cyc");
        idle(1);
        rd(A_GIN, 32'h0000_003C, "gpio_in_2cyc");
        wr(A_GIN, 32'h0000_00FF);
        rd(A_GIN, 32'h0000_003C, "gpio_in_write_ignored");

        // Timer compare hit at COUNT=5
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTL, 32'd1);
        rd(A_CNT, 32'd0, "cnt_start");
        idle(5);
        rd(A_CNT, 32'd5, "cnt_at_5");
        chk_irq(1'b0, "irq_before_hit");
        idle(1);
        chk_irq(1'b1, "irq_after_hit");
        rd(A_STS, 32'd1, "status_set");
        rd(A_CNT, 32'd6, "cnt_after_hit");
        rd(A_CTL, 32'd1, "control_read");
        wr(A_STS, 32'd0);
        chk_irq(1'b1, "status_write0_noeffect");
        wr(A_STS, 32'd1);
        chk_irq(1'b0, "irq_cleared");
        rd(A_STS, 32'd0, "status_cleared");
        rd(A_CNT, 32'd8, "cnt_after_clear");

        // Wrap and count load
        wr(A_CNT, 32'hFFFF_FFFE);
        rd(A_CNT, 32'hFFFF_FFFE, "cnt_load_no_inc");
        idle(1);
        rd(A_CNT, 32'hFFFF_FFFF, "cnt_max");
        idle(1);
        rd(A_CNT, 32'h0000_0000, "cnt_wrap");
        wr(A_CNT, 32'd7);
        rd(A_CNT, 32'd7, "cnt_load_7");
        idle(1);
        rd(A_CNT, 32'd8, "cnt_after_load");
        wr(A_CTL, 32'hFFFF_FFFF);
        rd(A_CTL, 32'd1, "control_upper_zero");

        // Clear and hit in the same cycle: set wins
        wr(A_CMP, 32'd12);
        idle(2);
        rd(A_CNT, 32'd12, "cnt_at_12");
        chk_irq(1'b0, "irq_before_race");
        wr(A_STS, 32'd1);
        chk_irq(1'b1, "set_wins_over_clear");
        rd(A_STS, 32'd1, "status_set_wins");

        // Disable holds the count
        wr(A_CTL, 32'd0);
        rd(A_CNT, 32'd14, "cnt_disable");
        idle(3);
        rd(A_CNT, 32'd14, "cnt_held");
        wr(A_CTL, 32'd1);
        idle(2);
        rd(A_CNT, 32'd16, "cnt_reenabled");

        // Reset mid-count with a RAM write in the same cycle
        reset        = 1'b1;
        address      = 32'h0000_0010;
        write_data   = 32'h0000_0BAD;
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
        chk_gpio(8'h00, "rst2_gpio_out");
        chk_irq(1'b0, "rst2_irq");
        rd(A_CNT, 32'd0,         "rst2_count");
        rd(A_CMP, 32'hFFFF_FFFF, "rst2_compare");
        rd(A_CTL, 32'd0,         "rst2_control");
        rd(A_STS, 32'd0,         "rst2_status");
        rd(A_GIN, 32'd0,         "rst2_gpio_in");
        idle(1);
        reset = 1'b0;
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept_over_reset");
        rd(32'h0000_03FC, 32'hCAFE_F00D, "ram_last_kept");
        idle(2);
        rd(A_GIN, 32'h0000_003C, "gpio_in_after_reset");
        rd(A_CNT, 32'd0, "cnt_stays_disabled");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: data RAM depth in 32-bit words, power of two, maximum 1024.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port address, input, 32 bits: byte address from the CPU; bits [1:0] ignored (word access only).
REQ-005 SHALL have port write_enable, input, 1 bit: write request for the current cycle.
REQ-006 SHALL have port write_data, input, 32 bits: write word.
REQ-007 SHALL have port read_data, output, 32 bits: read word, combinational from address and current state.
REQ-008 SHALL have port gpio_in, input, 8 bits: asynchronous external inputs.
REQ-009 SHALL have port gpio_out, output, 8 bits: registered external outputs.
REQ-010 SHALL have port timer_irq, output, 1 bit: timer interrupt, level, registered.

Function
REQ-011 SHALL decode this word map: RAM at 0x0000_0000 up to 4*RAM_WORDS-1; GPIO_OUT at 0x1000_0000; GPIO_IN at 0x1000_0004; TIMER_COUNT at 0x1000_0008; TIMER_COMPARE at 0x1000_000C; TIMER_CONTROL at 0x1000_0010; TIMER_STATUS at 0x1000_0014.
REQ-012 SHALL return 0 on reads of unmapped addresses and ignore writes to them, including RAM aliases at or above 4*RAM_WORDS.
REQ-013 SHALL perform reads in zero cycles: read_data reflects pre-edge state, so a read in a write cycle returns the old value.
REQ-014 SHALL commit writes at the rising edge when write_enable=1; the written value is readable from the next cycle.
REQ-015 SHALL return GPIO_OUT zero-extended on reads and drive gpio_out from its [7:0].
REQ-016 SHALL pass gpio_in through a two-flop synchroniser; a GPIO_IN read returns the synchronised value zero-extended, 2 cycles after a stable input change; writes ignored.
REQ-017 TIMER_CONTROL bit0 (enable) SHALL be read/write; bits [31:1] read 0.
REQ-018 While enable=1, TIMER_COUNT SHALL increment by 1 each cycle, wrapping 0xFFFF_FFFF->0; while enable=0 it holds.
REQ-019 A CPU write to TIMER_COUNT SHALL load write_data and suppress that cycle's increment.
REQ-020 When enable=1 and the pre-edge TIMER_COUNT equals TIMER_COMPARE, TIMER_STATUS bit0 (match) SHALL set at that edge.
REQ-021 Writing TIMER_STATUS with bit0=1 SHALL clear match; writing 0 has no effect; on a simultaneous set and clear, set wins.
REQ-022 timer_irq SHALL equal match from the same register; deasserts the cycle after a clear.

Reset
REQ-023 On reset SHALL clear GPIO_OUT, both synchroniser stages, TIMER_COUNT, TIMER_CONTROL and match; TIMER_COMPARE resets to 0xFFFF_FFFF; gpio_out=0, timer_irq=0.
REQ-024 RAM contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-025 Reset SHALL take priority over any write or increment in the same cycle.

Structure
REQ-026 Address constants and the RAM base/limit SHALL live in shared package memory_map_pkg, for use by the CPU test programs.
REQ-027 The counter, compare, control and status logic SHALL be sub-module timer with its own register interface; RAM and GPIO stay in the top.

Verification
REQ-028 Write 0xDEADBEEF to 0x0000_0010, read same cycle -> old value; next cycle -> 0xDEADBEEF; read 0x0000_0400 (RAM_WORDS=256) -> 0.
REQ-029 Write 0x1A5 to 0x1000_0000 -> gpio_out=0xA5 next cycle; set gpio_in=0x3C -> GPIO_IN read 0x3C after 2 cycles, not before.
REQ-030 Write COMPARE=5, CONTROL=1 with COUNT=0 -> match and timer_irq=1 after the edge where COUNT was 5; write STATUS=1 -> timer_irq=0 next cycle.
REQ-031 Write COUNT=0xFFFF_FFFE, enable -> reads 0xFFFF_FFFF then 0x0000_0000; a write of COUNT=7 mid-count -> reads 7, then 8.
REQ-032 Clear match in the same cycle as a new compare hit -> match stays 1.
REQ-033 Assert reset mid-count with RAM written -> all registers at reset values, RAM data intact.
